db_req_arb: RTL and testbench

- Shares one hash-table lookup engine (db controller) between two requester ports, A and B, such as two network RX paths.
- The engine has no ready/backpressure and needs op/key/hash held stable for several cycles after in_valid. This block serialises requests with round-robin arbitration and holds the request for the engine's full occupancy window.
- It collects the engine's sparse out_valid/out_flag result and returns a tagged response to the originating port.

---
 rtl/db_req_arb_if.sv | 56 +++++
 rtl/db_req_arb.sv | 159 +++++++++++++++
 tb/tb_db_req_arb.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/db_req_arb_if.sv
// Request/engine/response bundle for db_req_arb.
// The slave modport is the arbiter's view and the master modport is the view of
// the block that drives requests, models the engine and consumes responses.
interface db_req_arb_if #(
    parameter int HASH_SIZE = 32,
    parameter int KEY_SIZE  = 96,
    parameter int VAL_SIZE  = 32
);
    // requester port A
    logic                 a_valid;
    logic                 a_ready;
    logic [3:0]           a_op;
    logic [HASH_SIZE-1:0] a_hash;
    logic [KEY_SIZE-1:0]  a_key;
    logic [VAL_SIZE-1:0]  a_value;
    // requester port B
    logic                 b_valid;
    logic                 b_ready;
    logic [3:0]           b_op;
    logic [HASH_SIZE-1:0] b_hash;
    logic [KEY_SIZE-1:0]  b_key;
    logic [VAL_SIZE-1:0]  b_value;
    // lookup engine side
    logic                 db_valid;
    logic [3:0]           db_op;
    logic [HASH_SIZE-1:0] db_hash;
    logic [KEY_SIZE-1:0]  db_key;
    logic [VAL_SIZE-1:0]  db_value;
    logic                 db_out_valid;
    logic [3:0]           db_out_flag;
    // tagged response
    logic                 rsp_valid;
    logic                 rsp_port;
    logic                 rsp_hit;
    logic [3:0]           rsp_flag;

    modport slave (
        input  a_valid, a_op, a_hash, a_key, a_value,
        output a_ready,
        input  b_valid, b_op, b_hash, b_key, b_value,
        output b_ready,
        output db_valid, db_op, db_hash, db_key, db_value,
        input  db_out_valid, db_out_flag,
        output rsp_valid, rsp_port, rsp_hit, rsp_flag
    );

    modport master (
        output a_valid, a_op, a_hash, a_key, a_value,
        input  a_ready,
        output b_valid, b_op, b_hash, b_key, b_value,
        input  b_ready,
        input  db_valid, db_op, db_hash, db_key, db_value,
        output db_out_valid, db_out_flag,
        input  rsp_valid, rsp_port, rsp_hit, rsp_flag
    );
endinterface

// File: rtl/db_req_arb.sv
// db_req_arb: round-robin arbiter sharing one hash-table lookup engine between
// requester ports A and B. The engine has no backpressure, so a request is held
// stable on db_* for its whole occupancy window (DB_LAT cycles, legal 4..15)
// and the first result seen inside that window is returned to the winning port.
// Optional feature macro: DB_ARB_STATS_EN adds 32-bit grant/hit counters.
module db_req_arb #(
    parameter int HASH_SIZE = 32,
    parameter int KEY_SIZE  = 96,
    parameter int VAL_SIZE  = 32,
    parameter int DB_LAT    = 5
) (
    input  logic         clk,
    input  logic         rst,
    db_req_arb_if.slave  arb_bus
`ifdef DB_ARB_STATS_EN
    ,
    output logic [31:0]  stat_grant_a,
    output logic [31:0]  stat_grant_b,
    output logic [31:0]  stat_hit
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t               r_state;
    logic                 r_last_b;     // 1: last grant went to B
    logic                 r_tag;        // port owning the request in flight
    logic                 r_db_valid;
    logic [3:0]           r_op;
    logic [HASH_SIZE-1:0] r_hash;
    logic [KEY_SIZE-1:0]  r_key;
    logic [VAL_SIZE-1:0]  r_value;
    logic [3:0]           r_cnt;
    logic                 r_hit;
    logic [3:0]           r_flag;
    logic                 r_rsp_valid;
    logic                 r_rsp_port;
    logic                 r_rsp_hit;
    logic [3:0]           r_rsp_flag;

    logic                 w_idle;
    logic                 w_a_win;
    logic                 w_b_win;
    logic                 w_accept;
    logic                 w_hit_nxt;
    logic [3:0]           w_flag_nxt;
    logic                 w_resp_edge;

    // A tie goes to the port that did not win last time; a lone requester always wins.
    assign w_idle   = (r_state == S_IDLE);
    assign w_a_win  = w_idle && arb_bus.a_valid && (!arb_bus.b_valid || r_last_b);
    assign w_b_win  = w_idle && arb_bus.b_valid && (!arb_bus.a_valid || !r_last_b);
    assign w_accept = w_a_win || w_b_win;

    // Result as it stands including this cycle's pulse, so the last window cycle still counts.
    assign w_hit_nxt   = r_hit || arb_bus.db_out_valid;
    assign w_flag_nxt  = r_hit ? r_flag : (arb_bus.db_out_valid ? arb_bus.db_out_flag : 4'd0);
    assign w_resp_edge = (r_state == S_WAIT) && (r_cnt == 4'd0);

    assign arb_bus.a_ready   = w_a_win;
    assign arb_bus.b_ready   = w_b_win;
    assign arb_bus.db_valid  = r_db_valid;
    assign arb_bus.db_op     = r_op;
    assign arb_bus.db_hash   = r_hash;
    assign arb_bus.db_key    = r_key;
    assign arb_bus.db_value  = r_value;
    assign arb_bus.rsp_valid = r_rsp_valid;
    assign arb_bus.rsp_port  = r_rsp_port;
    assign arb_bus.rsp_hit   = r_rsp_hit;
    assign arb_bus.rsp_flag  = r_rsp_flag;

    // Arbitration FSM: accept, issue, hold for the engine window, then respond.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_last_b    <= 1'b1;
            r_tag       <= 1'b0;
            r_db_valid  <= 1'b0;
            r_op        <= '0;
            r_hash      <= '0;
            r_key       <= '0;
            r_value     <= '0;
            r_cnt       <= '0;
            r_hit       <= 1'b0;
            r_flag      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_port  <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_flag  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op       <= w_b_win ? arb_bus.b_op    : arb_bus.a_op;
                        r_hash     <= w_b_win ? arb_bus.b_hash  : arb_bus.a_hash;
                        r_key      <= w_b_win ? arb_bus.b_key   : arb_bus.a_key;
                        r_value    <= w_b_win ? arb_bus.b_value : arb_bus.a_value;
                        r_tag      <= w_b_win;
                        r_last_b   <= w_b_win;
                        r_db_valid <= 1'b1;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_db_valid <= 1'b0;
                    r_hit      <= 1'b0;
                    r_flag     <= 4'd0;
                    r_cnt      <= 4'(DB_LAT - 1);
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    // only the first result of the window is kept
                    if (arb_bus.db_out_valid && !r_hit) begin
                        r_hit  <= 1'b1;
                        r_flag <= arb_bus.db_out_flag;
                    end
                    if (r_cnt == 4'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_port  <= r_tag;
                        r_rsp_hit   <= w_hit_nxt;
                        r_rsp_flag  <= w_flag_nxt;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef DB_ARB_STATS_EN
    logic [31:0] r_stat_a;
    logic [31:0] r_stat_b;
    logic [31:0] r_stat_hit;

    // Free-running grant and hit counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stat_a   <= '0;
            r_stat_b   <= '0;
            r_stat_hit <= '0;
        end else begin
            if (w_a_win)                  r_stat_a   <= r_stat_a + 32'd1;
            if (w_b_win)                  r_stat_b   <= r_stat_b + 32'd1;
            if (w_resp_edge && w_hit_nxt) r_stat_hit <= r_stat_hit + 32'd1;
        end
    end

    assign stat_grant_a = r_stat_a;
    assign stat_grant_b = r_stat_b;
    assign stat_hit     = r_stat_hit;
`endif

endmodule

// File: tb/tb_db_req_arb.sv
// Testbench for db_req_arb: scoreboard of expected responses pushed at accept
// and popped at rsp_valid, plus an engine model driving scheduled results.
module tb_db_req_arb;
    localparam int HS     = 32;
    localparam int KS     = 96;
    localparam int VS     = 32;
    localparam int DB_LAT = 5;

    typedef struct {
        logic       port;
        logic       hit;
        logic [3:0] flag;
        int         acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    db_req_arb_if #(.HASH_SIZE(HS), .KEY_SIZE(KS), .VAL_SIZE(VS)) bus ();

`ifdef DB_ARB_STATS_EN
    logic [31:0] sga, sgb, shit;
`endif

    db_req_arb #(.HASH_SIZE(HS), .KEY_SIZE(KS), .VAL_SIZE(VS), .DB_LAT(DB_LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .arb_bus      (bus)
`ifdef DB_ARB_STATS_EN
        ,
        .stat_grant_a (sga),
        .stat_grant_b (sgb),
        .stat_hit     (shit)
`endif
    );

    exp_t       sb[$];
    int         glog[$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         eng_k1 = 0, eng_k2 = 0;
    logic [3:0] eng_f1 = 0, eng_f2 = 0;
    int         spur_req = 0, spur_ack = 0;
    logic [3:0] spur_flag = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // first scheduled pulse that lands inside the DB_LAT-cycle window
    task automatic exp_result(output logic hit, output logic [3:0] flag);
        bit in1, in2;
        in1 = (eng_k1 >= 1) && (eng_k1 <= DB_LAT);
        in2 = (eng_k2 >= 1) && (eng_k2 <= DB_LAT);
        hit = 1'b0;
        flag = 4'd0;
        if (in1 && (!in2 || eng_k1 < eng_k2)) begin
            hit = 1'b1; flag = eng_f1;
        end else if (in2) begin
            hit = 1'b1; flag = eng_f2;
        end
    endtask

    // Engine model: eng_w counts window cycles after the db_valid cycle.
    task automatic engine_loop();
        int eng_w = 0;
        forever begin
            @(negedge clk);
            bus.db_out_valid = 1'b0;
            bus.db_out_flag  = 4'd0;
            if (!rst) begin
                eng_w = 0;
            end else if (bus.db_valid) begin
                eng_w = 1;
            end else if (eng_w != 0) begin
                if (eng_w == eng_k1) begin
                    bus.db_out_valid = 1'b1; bus.db_out_flag = eng_f1;
                end else if (eng_w == eng_k2) begin
                    bus.db_out_valid = 1'b1; bus.db_out_flag = eng_f2;
                end
                eng_w = (eng_w == DB_LAT + 1) ? 0 : eng_w + 1;
            end else if (spur_req != spur_ack) begin
                bus.db_out_valid = 1'b1;
                bus.db_out_flag  = spur_flag;
                spur_ack = spur_req;
            end
        end
    endtask

    task automatic monitor_loop();
        logic        pa = 0, pb = 0, mon_act = 0, port, hit;
        logic [3:0]  flag, mon_op;
        logic [95:0] mon_key;
        int          mon_acc = 0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sb.delete();
                mon_act = 0; pa = 0; pb = 0;
                continue;
            end
            if (bus.a_ready) check_eq("a_ready_pulse", pa, 0);
            if (bus.b_ready) check_eq("b_ready_pulse", pb, 0);
            pa = bus.a_ready;
            pb = bus.b_ready;
            if ((bus.a_valid && bus.a_ready) || (bus.b_valid && bus.b_ready)) begin
                check_eq("ready_exclusive", bus.a_ready & bus.b_ready, 0);
                port = bus.b_valid && bus.b_ready;
                exp_result(hit, flag);
                sb.push_back('{port: port, hit: hit, flag: flag, acc: cyc});
                glog.push_back(int'(port));
                mon_acc = cyc;
                mon_act = 1;
                mon_key = port ? bus.b_key : bus.a_key;
                mon_op  = port ? bus.b_op  : bus.a_op;
            end else if (mon_act && cyc > mon_acc && cyc <= mon_acc + DB_LAT + 2) begin
                check_eq("db_key_hold", bus.db_key, mon_key);
                check_eq("db_op_hold", bus.db_op, mon_op);
                check_eq("db_valid_pulse", bus.db_valid, cyc == mon_acc + 1);
            end else begin
                check_eq("db_valid_idle", bus.db_valid, 0);
            end
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    check_eq("rsp_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("rsp_port", bus.rsp_port, e.port);
                    check_eq("rsp_hit", bus.rsp_hit, e.hit);
                    check_eq("rsp_flag", bus.rsp_flag, e.flag);
                    check_eq("rsp_latency", cyc - e.acc, DB_LAT + 2);
                end
            end
        end
    endtask

    task automatic send(input bit port, input logic [3:0] op, input logic [31:0] hash,
                        input logic [95:0] key, input logic [31:0] val);
        bit got = 0;
        @(posedge clk); #1;
        if (port) begin
            bus.b_op = op; bus.b_hash = hash; bus.b_key = key; bus.b_value = val; bus.b_valid = 1;
        end else begin
            bus.a_op = op; bus.a_hash = hash; bus.a_key = key; bus.a_value = val; bus.a_valid = 1;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = port ? bus.b_ready : bus.a_ready;
        end
        if (!got) check_eq("accept_timeout", 0, 1);
        @(posedge clk); #1;
        bus.a_valid = 0;
        bus.b_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) check_eq("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic set_plan(input int k1, input logic [3:0] f1, input int k2, input logic [3:0] f2);
        eng_k1 = k1; eng_f1 = f1; eng_k2 = k2; eng_f2 = f2;
    endtask

    initial begin
        int g0;
        bus.a_valid = 0; bus.a_op = 0; bus.a_hash = 0; bus.a_key = 0; bus.a_value = 0;
        bus.b_valid = 0; bus.b_op = 0; bus.b_hash = 0; bus.b_key = 0; bus.b_value = 0;
        bus.db_out_valid = 0; bus.db_out_flag = 0;
        fork
            engine_loop();
            monitor_loop();
        join_none

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_db_valid", bus.db_valid, 0);
        check_eq("rst_db_key", bus.db_key, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_flag", bus.rsp_flag, 0);
        @(posedge clk); #1 rst = 1;

        // single GET on A, no result
        set_plan(0, 0, 0, 0);
        send(0, 4'b0000, 32'h5, 96'h1234, 32'h0);
        drain();
        // SET on B, hit in window cycle 3
        set_plan(3, 4'b0100, 0, 0);
        send(1, 4'b0011, 32'h77, 96'hABCD_0001, 32'hDEAD);
        drain();
        // hit on the last window cycle
        set_plan(DB_LAT, 4'h9, 0, 0);
        send(0, 4'b0001, 32'h1, 96'h55, 32'h1);
        drain();
        // result during RESP is outside the window
        set_plan(DB_LAT + 1, 4'hF, 0, 0);
        send(1, 4'b0000, 32'h2, 96'h66, 32'h2);
        drain();
        check_eq("rsp_hold_port", bus.rsp_port, 1);
        check_eq("rsp_hold_valid", bus.rsp_valid, 0);

        // contention: both valid for four grants
        set_plan(0, 0, 0, 0);
        g0 = glog.size();
        @(posedge clk); #1;
        bus.a_key = 96'hA0; bus.b_key = 96'hB0; bus.a_valid = 1; bus.b_valid = 1;
        for (int i = 0; i < 100 && glog.size() < g0 + 4; i++) @(negedge clk);
        check_eq("contention_count", glog.size() >= g0 + 4, 1);
        @(posedge clk); #1;
        bus.a_valid = 0; bus.b_valid = 0;
        for (int k = 0; k < 4; k++)
            if (glog.size() > g0 + k) check_eq("contention_order", glog[g0 + k], k % 2);
        drain();

        // spurious result in IDLE, then two results in the window
        spur_flag = 4'h2;
        spur_req++;
        repeat (3) @(negedge clk);
        set_plan(2, 4'h6, 4, 4'h8);
        send(0, 4'b0001, 32'h9, 96'h99, 32'h9);
        drain();

        // reset during WAIT; A had the last grant
        set_plan(0, 0, 0, 0);
        send(0, 4'b0001, 32'h3, 96'hFACE, 32'h3);
        @(posedge clk); #1 rst = 0;
        @(posedge clk);
        @(negedge clk);
        check_eq("midrst_db_valid", bus.db_valid, 0);
        check_eq("midrst_db_key", bus.db_key, 0);
        check_eq("midrst_db_hash", bus.db_hash, 0);
        check_eq("midrst_rsp_valid", bus.rsp_valid, 0);
        check_eq("midrst_rsp_flag", bus.rsp_flag, 0);
        check_eq("midrst_rsp_hit", bus.rsp_hit, 0);
        @(posedge clk); #1 rst = 1;
        repeat (DB_LAT + 4) @(negedge clk);

        // first post-reset tie goes to A
        g0 = glog.size();
        @(posedge clk); #1;
        bus.a_key = 96'hA1; bus.b_key = 96'hB1; bus.a_valid = 1; bus.b_valid = 1;
        for (int i = 0; i < 50 && glog.size() <= g0; i++) @(negedge clk);
        @(posedge clk); #1 bus.a_valid = 0;
        for (int i = 0; i < 50 && glog.size() <= g0 + 1; i++) @(negedge clk);
        @(posedge clk); #1 bus.b_valid = 0;
        check_eq("postrst_grants", glog.size() >= g0 + 2, 1);
        if (glog.size() >= g0 + 2) begin
            check_eq("postrst_first", glog[g0], 0);
            check_eq("postrst_second", glog[g0 + 1], 1);
        end
        drain();

        // bring totals since reset to A=3, B=2, hits=1
        set_plan(2, 4'h1, 0, 0);
        send(0, 4'b0001, 32'h4, 96'h44, 32'h4);
        drain();
        set_plan(0, 0, 0, 0);
        send(0, 4'b0000, 32'h5, 96'h45, 32'h5);
        drain();
        send(1, 4'b0000, 32'h6, 96'h46, 32'h6);
        drain();
`ifdef DB_ARB_STATS_EN
        check_eq("stat_grant_a", sga, 3);
        check_eq("stat_grant_b", sgb, 2);
        check_eq("stat_hit", shit, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
